// File: rtl/conv_layer_sequencer_if.sv
// rtl/conv_layer_sequencer_if.sv - config stream, layer memory write port and frame handshake bundle
interface conv_layer_sequencer_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 4
);
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [WORD_SIZE-1:0] cfg_data_i;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 wen_o;
  logic [WORD_SIZE-1:0] mem_data_o;
  logic                 frame_valid_i;
  logic                 frame_ready_o;

  modport master (
    output cfg_valid_i, cfg_data_i, frame_valid_i,
    input  cfg_ready_o, mem_addr_o, wen_o, mem_data_o, frame_ready_o
  );

  modport slave (
    input  cfg_valid_i, cfg_data_i, frame_valid_i,
    output cfg_ready_o, mem_addr_o, wen_o, mem_data_o, frame_ready_o
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - loads conv_layer weights from a config stream, then sequences frames
module conv_layer_sequencer #(
  parameter int WORD_SIZE          = 16,
  parameter int INPUT_LAYER_HEIGHT = 5,
  parameter int KERNEL_HEIGHT      = 3,
  parameter int KERNEL_WIDTH       = 2,
  parameter int N_CONVOLUTIONS     = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  conv_layer_sequencer_if.slave bus,
  input  logic reload_i,
  output logic start_o,
  input  logic out_valid_i,
  input  logic out_ready_i,
  output logic loaded_o,
  output logic busy_o,
  output logic done_o
);

  localparam int KW    = KERNEL_HEIGHT * KERNEL_WIDTH + 1;
  localparam int N_OUT = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
  localparam int IW    = $clog2(N_CONVOLUTIONS + 1);
  localparam int AW    = $clog2(KW);
  localparam int CW    = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {LOAD, IDLE, START, RUN} state_t;

  state_t state, state_next;

  logic          accept;
  logic          last_word;
  logic          handshake;
  logic          finish;
  logic [IW-1:0] k;
  logic [AW-1:0] a;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= LOAD;
    else         state <= state_next;
  end

  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    last_word         = 1'b0;
    handshake         = 1'b0;
    finish            = 1'b0;
    bus.cfg_ready_o   = (state == LOAD);
    bus.frame_ready_o = (state == IDLE);
    case (state)
      LOAD: begin
        accept    = bus.cfg_valid_i;
        last_word = accept && (k == IW'(N_CONVOLUTIONS - 1)) && (a == AW'(KW - 1));
        if (last_word) state_next = IDLE;
      end
      IDLE: begin
        // a simultaneous frame request beats a reload request
        if (bus.frame_valid_i) state_next = START;
        else if (reload_i)     state_next = LOAD;
      end
      START: state_next = RUN;
      RUN: begin
        handshake = out_valid_i && out_ready_i;
        finish    = handshake && (cnt == CW'(N_OUT - 1));
        if (finish) state_next = IDLE;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      k              <= '0;
      a              <= '0;
      cnt            <= '0;
      bus.wen_o      <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
      start_o        <= 1'b0;
      done_o         <= 1'b0;
      loaded_o       <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      bus.wen_o <= accept;
      if (accept) begin
        // memory index 0 is reserved, so kernel k lives at index k+1
        bus.mem_addr_o <= {k + IW'(1), a};
        bus.mem_data_o <= bus.cfg_data_i;
        if (a == AW'(KW - 1)) begin
          a <= '0;
          k <= k + IW'(1);
        end else begin
          a <= a + AW'(1);
        end
      end
      if (last_word) loaded_o <= 1'b1;
      if (state == IDLE && state_next == LOAD) begin
        loaded_o <= 1'b0;
        k        <= '0;
        a        <= '0;
      end
      if (state == START)  cnt <= '0;
      else if (handshake)  cnt <= cnt + CW'(1);
      start_o <= (state == IDLE) && (state_next == START);
      done_o  <= finish;
      busy_o  <= (state_next == START) || (state_next == RUN) || finish;
    end
  end

endmodule
